// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
//
// Serialises a stereo pair of 16-bit two's-complement samples onto a standard
// Philips I2S link. A 64-BCLK frame carries 32 slots per channel. The sample
// MSB goes in slot 1 of each half, which gives the one-BCLK I2S delay. All
// other slots carry 0. Samples are double-buffered: a strobe fills the holding
// registers, and the serial shift registers reload from them once per frame.
//
// Ports
//   clk_in           in   system clock (100 MHz)
//   rst_in           in   synchronous active-high reset
//   left_sample_in   in   [15:0] signed left-channel sample
//   right_sample_in  in   [15:0] signed right-channel sample
//   new_sample_in    in   one-cycle strobe, both samples valid
//   mute_in          in   forces an all-zero frame, sampled at frame load
//   i2s_bclk_out     out  serial bit clock
//   i2s_lrclk_out    out  word select (0 = left, 1 = right)
//   i2s_data_out     out  serial data, MSB first
//   frame_start_out  out  one-cycle pulse on frame load
//   underrun_out     out  one-cycle pulse: frame loaded with nothing pending
//   overrun_out      out  one-cycle pulse: strobe while a sample is pending
// ---------------------------------------------------------------------------
module i2s_transmitter #(
  parameter int BCLK_HALF_DIV = 12
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] left_sample_in,
  input  logic [15:0] right_sample_in,
  input  logic        new_sample_in,
  input  logic        mute_in,
  output logic        i2s_bclk_out,
  output logic        i2s_lrclk_out,
  output logic        i2s_data_out,
  output logic        frame_start_out,
  output logic        underrun_out,
  output logic        overrun_out
);

  localparam int DIV_W = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [15:0]      hold_left;
  logic [15:0]      hold_right;
  logic [15:0]      shift_left;
  logic [15:0]      shift_right;
  logic             pending;

  logic             div_tc;
  logic             fall_evt;
  logic             frame_load;
  logic [5:0]       next_slot;
  logic [4:0]       slot_in_half;
  logic             data_slot;

  // Every serial output changes in the same cycle that bclk drops. For that
  // reason, the data for the slot being entered is computed from the
  // incremented count.
  assign div_tc       = (div_cnt == DIV_LAST);
  assign fall_evt     = div_tc && i2s_bclk_out;
  assign frame_load   = fall_evt && (bit_cnt == 6'd63);
  assign next_slot    = bit_cnt + 6'd1;
  assign slot_in_half = next_slot[4:0];
  assign data_slot    = (slot_in_half >= 5'd1) && (slot_in_half <= 5'd16);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt      <= '0;
      i2s_bclk_out <= 1'b0;
    end else if (div_tc) begin
      div_cnt      <= '0;
      i2s_bclk_out <= ~i2s_bclk_out;
    end else begin
      div_cnt      <= div_cnt + DIV_W'(1);
    end
  end

  // The shift registers only move in the sixteen data slots of each half.
  // The bits shifted in at the bottom are zeros.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bit_cnt         <= '0;
      i2s_lrclk_out   <= 1'b0;
      i2s_data_out    <= 1'b0;
      shift_left      <= '0;
      shift_right     <= '0;
      frame_start_out <= 1'b0;
    end else begin
      frame_start_out <= frame_load;
      if (fall_evt) begin
        bit_cnt       <= next_slot;
        i2s_lrclk_out <= next_slot[5];
        if (frame_load) begin
          shift_left   <= mute_in ? 16'h0000 : hold_left;
          shift_right  <= mute_in ? 16'h0000 : hold_right;
          i2s_data_out <= 1'b0;
        end else if (data_slot) begin
          if (next_slot[5]) begin
            i2s_data_out <= shift_right[15];
            shift_right  <= {shift_right[14:0], 1'b0};
          end else begin
            i2s_data_out <= shift_left[15];
            shift_left   <= {shift_left[14:0], 1'b0};
          end
        end else begin
          i2s_data_out <= 1'b0;
        end
      end
    end
  end

  // A strobe that lands on the load cycle misses the current frame. The frame
  // takes the old holding contents. The new strobe keeps pending set so the
  // next frame picks it up.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_left    <= '0;
      hold_right   <= '0;
      pending      <= 1'b0;
      underrun_out <= 1'b0;
      overrun_out  <= 1'b0;
    end else begin
      underrun_out <= frame_load && !pending;
      overrun_out  <= new_sample_in && pending && !frame_load;
      if (new_sample_in) begin
        hold_left  <= left_sample_in;
        hold_right <= right_sample_in;
      end
      if (frame_load) begin
        pending <= new_sample_in;
      end else if (new_sample_in) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// ---------------------------------------------------------------------------
// tb_i2s_transmitter
//
// Directed bench for i2s_transmitter. Each table row covers one frame window,
// running from one frame load to the next. A row holds the strobes and the
// mute level applied during the window. It also holds the words the bench
// expects to see serialised in that window, which belong to the frame loaded
// at the start of the window. Finally, it gives the underrun and overrun
// activity expected at the closing load. Startup timing and a mid-frame reset
// are written out by hand.
// ---------------------------------------------------------------------------
module tb_i2s_transmitter;

  localparam int HALF  = 12;
  localparam int FRAME = 64 * 2 * HALF;

  typedef struct {
    bit          has1;
    logic [15:0] l1;
    logic [15:0] r1;
    bit          has2;
    bit          s2_at_load;
    logic [15:0] l2;
    logic [15:0] r2;
    bit          mute;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    bit          exp_under;
    int          exp_over;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] left_sample_in;
  logic [15:0] right_sample_in;
  logic        new_sample_in;
  logic        mute_in;
  logic        i2s_bclk_out;
  logic        i2s_lrclk_out;
  logic        i2s_data_out;
  logic        frame_start_out;
  logic        underrun_out;
  logic        overrun_out;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor state, reset whenever the DUT leaves reset.
  int          cyc;
  int          phase_len;
  bit          prev_bclk;
  bit          prev_lr;
  bit          prev_data;
  logic [5:0]  slot;
  logic [15:0] cap_l;
  logic [15:0] cap_r;
  logic [15:0] last_l;
  logic [15:0] last_r;
  int          zero_err;
  int          last_zero_err;
  int          timing_err;
  int          over_cnt;
  int          rise_count;
  int          first_rise;
  int          second_rise;
  int          first_fall;

  vec_t vecs[10];
  vec_t post_rst_vec;

  always #5 clk_in = ~clk_in;

  i2s_transmitter #(.BCLK_HALF_DIV(HALF)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .left_sample_in  (left_sample_in),
    .right_sample_in (right_sample_in),
    .new_sample_in   (new_sample_in),
    .mute_in         (mute_in),
    .i2s_bclk_out    (i2s_bclk_out),
    .i2s_lrclk_out   (i2s_lrclk_out),
    .i2s_data_out    (i2s_data_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out),
    .overrun_out     (overrun_out)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic monitor_reset();
    cyc           = 0;
    phase_len     = 0;
    prev_bclk     = 1'b0;
    prev_lr       = 1'b0;
    prev_data     = 1'b0;
    slot          = 6'd0;
    cap_l         = 16'h0;
    cap_r         = 16'h0;
    last_l        = 16'h0;
    last_r        = 16'h0;
    zero_err      = 0;
    last_zero_err = 0;
    timing_err    = 0;
    over_cnt      = 0;
    rise_count    = 0;
    first_rise    = -1;
    second_rise   = -1;
    first_fall    = -1;
  endtask

  // Advance one clock and sample the outputs 1 ns after the edge. The bench
  // tracks its own slot count from bclk falls and rebuilds the words from it.
  task automatic step();
    bit fall;
    int k;
    @(posedge clk_in);
    #1;
    cyc++;
    phase_len++;
    fall = prev_bclk && !i2s_bclk_out;
    if (i2s_bclk_out != prev_bclk) begin
      if (phase_len != HALF) timing_err++;
      phase_len = 0;
      if (i2s_bclk_out) begin
        rise_count++;
        if (rise_count == 1) first_rise = cyc;
        else if (rise_count == 2) second_rise = cyc;
      end else if (first_fall < 0) begin
        first_fall = cyc;
      end
    end
    if (!fall && ((i2s_lrclk_out != prev_lr) || (i2s_data_out != prev_data)))
      timing_err++;
    if (overrun_out) over_cnt++;
    if (fall) begin
      slot = slot + 6'd1;
      if (i2s_lrclk_out !== slot[5]) timing_err++;
      if (frame_start_out !== (slot == 6'd0)) timing_err++;
      k = int'(slot[4:0]);
      if (k >= 1 && k <= 16) begin
        if (slot[5]) cap_r[16-k] = i2s_data_out;
        else         cap_l[16-k] = i2s_data_out;
      end else if (i2s_data_out !== 1'b0) begin
        zero_err++;
      end
      if (slot == 6'd0) begin
        last_l        = cap_l;
        last_r        = cap_r;
        last_zero_err = zero_err;
        cap_l         = 16'h0;
        cap_r         = 16'h0;
        zero_err      = 0;
      end
    end else if (frame_start_out) begin
      timing_err++;
    end
    prev_bclk = i2s_bclk_out;
    prev_lr   = i2s_lrclk_out;
    prev_data = i2s_data_out;
  endtask

  // Drive the inputs for window cycle c. Cycle FRAME is the edge on which the
  // DUT performs its frame load.
  task automatic apply_stimulus(input vec_t v, input int c);
    new_sample_in   = 1'b0;
    left_sample_in  = 16'hDEAD;
    right_sample_in = 16'hBEEF;
    if (v.has1 && c == 100) begin
      new_sample_in   = 1'b1;
      left_sample_in  = v.l1;
      right_sample_in = v.r1;
    end
    if (v.has2 && ((!v.s2_at_load && c == 200) || (v.s2_at_load && c == FRAME))) begin
      new_sample_in   = 1'b1;
      left_sample_in  = v.l2;
      right_sample_in = v.r2;
    end
    mute_in = ((c >= 300) && (c < 310)) || (v.mute && (c >= 1400));
  endtask

  task automatic run_window(input vec_t v, input int idx);
    bit   seen;
    int   load_c;
    logic under_at_load;
    seen          = 1'b0;
    load_c        = -1;
    under_at_load = 1'b0;
    over_cnt      = 0;
    timing_err    = 0;
    for (int c = 1; c <= FRAME + 64 && !seen; c++) begin
      apply_stimulus(v, c);
      step();
      if (frame_start_out === 1'b1) begin
        seen          = 1'b1;
        load_c        = c;
        under_at_load = underrun_out;
      end
    end
    new_sample_in = 1'b0;
    mute_in       = 1'b0;
    check_output($sformatf("w%0d load_cycle", idx), load_c, FRAME);
    check_output($sformatf("w%0d underrun", idx), {31'd0, under_at_load}, {31'd0, v.exp_under});
    check_output($sformatf("w%0d overrun_count", idx), over_cnt, v.exp_over);
    check_output($sformatf("w%0d left_word", idx), {16'd0, last_l}, {16'd0, v.exp_l});
    check_output($sformatf("w%0d right_word", idx), {16'd0, last_r}, {16'd0, v.exp_r});
    check_output($sformatf("w%0d idle_slots_nonzero", idx), last_zero_err, 0);
    check_output($sformatf("w%0d timing_errors", idx), timing_err, 0);
  endtask

  task automatic check_startup(input string tag);
    check_output({tag, " first_rise"}, first_rise, HALF);
    check_output({tag, " first_fall"}, first_fall, 2 * HALF);
    check_output({tag, " second_rise"}, second_rise, 3 * HALF);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h8001, 16'h7FFE, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                16'h0000, 16'h0000, 1'b0, 0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                16'h8001, 16'h7FFE, 1'b1, 0};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                16'h8001, 16'h7FFE, 1'b1, 0};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                16'h8001, 16'h7FFE, 1'b1, 0};
    vecs[4] = '{1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h00FF, 16'h1100, 1'b0,
                16'h8001, 16'h7FFE, 1'b0, 1};
    vecs[5] = '{1'b1, 16'h5A5A, 16'hC3C3, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1,
                16'h00FF, 16'h1100, 1'b0, 0};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                16'h0000, 16'h0000, 1'b1, 0};
    vecs[7] = '{1'b1, 16'h1111, 16'h2222, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b0,
                16'h5A5A, 16'hC3C3, 1'b0, 0};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                16'h1111, 16'h2222, 1'b0, 0};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1,
                16'hAAAA, 16'h5555, 1'b1, 0};
    post_rst_vec = '{1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                     16'h0000, 16'h0000, 1'b0, 0};

    rst_in          = 1'b1;
    new_sample_in   = 1'b1;
    mute_in         = 1'b0;
    left_sample_in  = 16'h1357;
    right_sample_in = 16'h2468;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
    end
    check_output("reset outputs",
                 {26'd0, i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
                  frame_start_out, underrun_out, overrun_out}, 32'd0);
    new_sample_in = 1'b0;
    rst_in        = 1'b0;
    monitor_reset();

    for (int i = 0; i < 10; i++) begin
      run_window(vecs[i], i);
      if (i == 0) check_startup("boot");
    end

    // Muted frame in flight: run into slot 40, then reset mid-frame.
    timing_err = 0;
    for (int c = 1; c <= 40 * 2 * HALF + 6; c++) step();
    check_output("muted slot_reached", {26'd0, slot}, 32'd40);
    check_output("muted left_word", {16'd0, cap_l}, 32'd0);
    check_output("muted right_partial", {16'd0, cap_r}, 32'd0);
    check_output("muted idle_slots_nonzero", zero_err, 0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check_output("midframe reset outputs",
                 {26'd0, i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
                  frame_start_out, underrun_out, overrun_out}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    monitor_reset();
    run_window(post_rst_vec, 10);
    check_startup("restart");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
